// File: rtl/uart_sort_pkg.sv
// Shared types and defaults for the UART bubble-sort controller slice.
package uart_sort_pkg;

  localparam int N_BYTES_DEF = 8;
  localparam int IDX_W_DEF   = 4;

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_SORT    = 3'd1,
    S_TX_LOAD = 3'd2,
    S_TX_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/uart_sort_buffer.sv
// N_BYTES x 8 register file with one adjacent compare/swap unit (slot cmp_idx vs cmp_idx+1).
module uart_sort_buffer
  import uart_sort_pkg::*;
#(
  parameter int N_BYTES = N_BYTES_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             cmp_en,
  input  logic [IDX_W-1:0] cmp_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data,
  output logic             swap_flag
);

  logic [7:0]       mem [N_BYTES];
  logic [7:0]       lo_byte;
  logic [7:0]       hi_byte;
  logic [IDX_W-1:0] hi_idx;

  assign hi_idx = cmp_idx + IDX_W'(1);

  // Index decode by loop keeps the index width independent of N_BYTES.
  always_comb begin
    rd_data = '0;
    lo_byte = '0;
    hi_byte = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (IDX_W'(i) == rd_idx)  rd_data = mem[i];
      if (IDX_W'(i) == cmp_idx) lo_byte = mem[i];
      if (IDX_W'(i) == hi_idx)  hi_byte = mem[i];
    end
  end

  // Strict greater-than: equal bytes never swap.
  assign swap_flag = lo_byte > hi_byte;

  // NOTE: the buffer must read back as 8'h00 after reset, so this small array is
  // reset like ordinary flops; a large RAM would be left unreset instead.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < N_BYTES; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < N_BYTES; i++) begin
        if (wr_en && IDX_W'(i) == wr_idx) begin
          mem[i] <= wr_data;
        end else if (cmp_en && swap_flag) begin
          if (IDX_W'(i) == cmp_idx)     mem[i] <= hi_byte;
          else if (IDX_W'(i) == hi_idx) mem[i] <= lo_byte;
        end
      end
    end
  end

endmodule

// File: rtl/uart_sort_ctrl.sv
// Sequencer between uart_rx and uart_tx: collect a frame, bubble-sort it in place,
// then stream it out one byte per Tx handshake.
module uart_sort_ctrl
  import uart_sort_pkg::*;
#(
  parameter int N_BYTES = N_BYTES_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Tx_Done,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  output logic       o_Busy,
  output logic       o_Overrun,
  output logic       o_Frame_Done
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N_BYTES - 2);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] count, count_nxt;
  logic [IDX_W-1:0] pass, pass_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             swapped, swapped_nxt;
  logic             wr_en, cmp_en, tx_load, swap_flag;
  logic [7:0]       rd_data;

  uart_sort_buffer #(.N_BYTES(N_BYTES), .IDX_W(IDX_W)) u_buffer (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .wr_en    (wr_en),
    .wr_idx   (count),
    .wr_data  (i_Rx_Byte),
    .cmp_en   (cmp_en),
    .cmp_idx  (idx),
    .rd_idx   (count),
    .rd_data  (rd_data),
    .swap_flag(swap_flag)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state   <= S_COLLECT;
      count   <= '0;
      pass    <= '0;
      idx     <= '0;
      swapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      pass    <= pass_nxt;
      idx     <= idx_nxt;
      swapped <= swapped_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned (no latches); blocking '=' is correct here, '<=' only in always_ff.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pass_nxt    = pass;
    idx_nxt     = idx;
    swapped_nxt = swapped;
    wr_en       = 1'b0;
    cmp_en      = 1'b0;
    tx_load     = 1'b0;
    case (state)
      S_COLLECT: begin
        if (i_Rx_DV) begin
          wr_en = 1'b1;
          if (count == LAST_IDX) begin
            count_nxt   = '0;
            pass_nxt    = '0;
            idx_nxt     = '0;
            swapped_nxt = 1'b0;
            state_nxt   = S_SORT;
          end else begin
            count_nxt = count + IDX_W'(1);
          end
        end
      end
      S_SORT: begin
        cmp_en = 1'b1;
        // The swap decided this cycle counts toward the pass's early-exit test.
        if (idx == LAST_PASS - pass) begin
          if (!(swapped || swap_flag) || pass == LAST_PASS) begin
            count_nxt = '0;
            state_nxt = S_TX_LOAD;
          end else begin
            pass_nxt    = pass + IDX_W'(1);
            idx_nxt     = '0;
            swapped_nxt = 1'b0;
          end
        end else begin
          idx_nxt     = idx + IDX_W'(1);
          swapped_nxt = swapped || swap_flag;
        end
      end
      S_TX_LOAD: begin
        tx_load   = 1'b1;
        state_nxt = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (i_Tx_Done) begin
          if (count == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            count_nxt = count + IDX_W'(1);
            state_nxt = S_TX_LOAD;
          end
        end
      end
      S_DONE: begin
        count_nxt = '0;
        state_nxt = S_COLLECT;
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  // Tx strobe and byte are registered together so the byte is valid with the strobe.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
      o_Overrun <= 1'b0;
    end else begin
      o_Tx_DV   <= tx_load;
      if (tx_load) o_Tx_Byte <= rd_data;
      o_Overrun <= i_Rx_DV && (state != S_COLLECT);
    end
  end

  assign o_Busy       = (state != S_COLLECT);
  assign o_Frame_Done = (state == S_DONE);

endmodule
